ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle control unit for the SISC processor, sitting directly upstream of the ALU, register file, program counter and data memory. It decodes the instruction register, sequences each instruction through fetch/decode/execute/memory/writeback, and drives the ALU `alu_op` override plus all datapath write enables and mux selects. It also evaluates branch conditions against the status register and counts retired instructions.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  current IR contents; opcode `instr[31:28]`, condition mask `instr[27:24]`.
- `stat`  in  4  status register: {C, V, N, Z}.
- `ir_load`  out  1  load IR from instruction memory.
- `pc_write`  out  1  PC register write enable.
- `pc_sel`  out  1  0 = PC+1, 1 = branch target.
- `br_sel`  out  1  0 = PC-relative target, 1 = absolute target.
- `pc_rst`  out  1  force PC to 0.
- `rf_we`  out  1  register file write enable.
- `wb_sel`  out  1  writeback source: 0 = ALU result, 1 = data memory.
- `rb_sel`  out  1  1 = route Rd to register-file read port B (stores).
- `alu_op`  out  2  ALU override: bit1 = suppress status save, bit0 = use immediate.
- `dm_we`  out  1  data memory write enable.
- `halt`  out  1  processor halted.
- `instr_cnt`  out  CNT_W  retired-instruction count.

## Operation
- Opcodes: 0 NOP, 1 ALU (reg-reg, function in `instr[3:0]`), 2 ADDI, 3 LOD, 4 STR, 5 BRA (absolute), 6 BRR (relative), 7 BNE (relative), F HLT; 8–E undefined.
- States: RESET, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- RESET -> FETCH -> DECODE. From DECODE: NOP -> FETCH; HLT -> HALT; undefined -> FETCH (treated as NOP, see Configuration); all others -> EXECUTE.
- From EXECUTE: ALU, ADDI -> WB; LOD, STR -> MEM; branches -> FETCH. From MEM: LOD -> WB; STR -> FETCH. WB -> FETCH. HALT is absorbing until `rst_n` is asserted.
- Cycles per instruction: NOP 2, branch 3, ALU/ADDI/STR 4, LOD 5.
- Outputs are combinational from state and opcode. Any output not listed for a state is 0, except `alu_op`, whose default is 2'b10.
- RESET: `pc_rst`=1.
- FETCH: `ir_load`=1, `pc_write`=1, `pc_sel`=0.
- EXECUTE:
  - ALU: `alu_op`=00.
  - ADDI, LOD, STR: `alu_op`=11.
  - STR: `rb_sel`=1.
- Branch taken when:
  - BRA/BRR: mask==0 or (mask & stat)!=0.
  - BNE: (mask & stat)==0.
- Taken branch drives, in EXECUTE: `pc_write`=1, `pc_sel`=1, `br_sel`=1 for BRA and 0 for BRR/BNE. Not-taken branch writes nothing.
- MEM:
  - `alu_op`=11 held.
  - STR: `rb_sel`=1, `dm_we`=1.
- WB:
  - `rf_we`=1.
  - `wb_sel`=1 for LOD, else 0.
  - `alu_op`=00 (ALU) or 11 (ADDI, LOD) held from EXECUTE.
- `instr_cnt` increments by 1 on the final cycle of every instruction, including NOP, HLT and undefined opcodes. It wraps from all-ones to 0.

## Timing
- Reset (asynchronous): state=RESET; `pc_rst`=1, `alu_op`=10, `instr_cnt`=0; all other outputs 0.
- First rising edge after `rst_n` deasserts enters FETCH.
- Assertion mid-instruction aborts immediately; no write enable may be seen high after `rst_n` falls.
- The ALU latches its result on the edge ending EXECUTE, so WB writes the registered result.
- `stat` is sampled combinationally during EXECUTE only. A status update from the preceding ALU instruction has completed by then.
- `halt` rises in the cycle after the HLT DECODE and stays 1. In HALT every enable is 0.

## Configuration
- `CTRL_ILLEGAL_HALT_EN` defined: undefined opcodes (8–E) go DECODE -> HALT, same as HLT.
- Not defined: undefined opcodes retire as 2-cycle NOPs.

## Test plan
- Reset: hold `rst_n`=0 -> `pc_rst`=1, `instr_cnt`=0, all enables 0. Release -> `ir_load` pulses on the next cycle.
- ALU instr 0x1000_0001 -> 4 cycles; `alu_op`=00 in EXECUTE and WB; `rf_we`=1 only in WB with `wb_sel`=0; `instr_cnt` +1.
- LOD 0x3...: 5 cycles, `alu_op`=11 in EXECUTE/MEM/WB, `wb_sel`=1 in WB. STR 0x4...: `dm_we`=1 and `rb_sel`=1 in MEM, `rf_we` never 1.
- BRR with mask=0001:
  - stat=0001 -> `pc_write`=1, `pc_sel`=1, `br_sel`=0 in EXECUTE.
  - stat=0000 -> no PC write.
  - BNE, same cases -> inverse result.
- Opcode 0xA:
  - Without macro: 2 cycles, then FETCH.
  - With `CTRL_ILLEGAL_HALT_EN`: `halt`=1 held for 20 cycles.
- Pull `rst_n` low during LOD MEM -> outputs return to reset values the same cycle, `rf_we` never asserted. Separately, preload `instr_cnt` near all-ones -> wraps to 0.

Source files
------------

// File: rtl/ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// ctrl_fsm_if
// Bundles the SISC control unit's datapath-facing signals: the instruction
// register and status register it reads, and every write enable, mux select
// and ALU override it drives back into the datapath.
//
// Parameter:
//   CNT_W     width of the retired-instruction counter
//
// Signals:
//   instr     [31:0]  IR contents; opcode [31:28], condition mask [27:24]
//   stat      [3:0]   status register {C, V, N, Z}
//   ir_load           load IR from instruction memory
//   pc_write          PC write enable
//   pc_sel            0 = PC+1, 1 = branch target
//   br_sel            0 = PC-relative target, 1 = absolute target
//   pc_rst            force PC to 0
//   rf_we             register file write enable
//   wb_sel            writeback source: 0 = ALU, 1 = data memory
//   rb_sel            route Rd to register-file read port B (stores)
//   alu_op    [1:0]   bit1 = suppress status save, bit0 = use immediate
//   dm_we             data memory write enable
//   halt              processor halted
//   instr_cnt         retired-instruction count
//
// Modports:
//   master    the control unit (reads instr/stat, drives controls)
//   slave     the datapath side (drives instr/stat, reads controls)
// ----------------------------------------------------------------------------
interface ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr;
    logic [3:0]       stat;
    logic             ir_load;
    logic             pc_write;
    logic             pc_sel;
    logic             br_sel;
    logic             pc_rst;
    logic             rf_we;
    logic             wb_sel;
    logic             rb_sel;
    logic [1:0]       alu_op;
    logic             dm_we;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  instr, stat,
        output ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we,
               wb_sel, rb_sel, alu_op, dm_we, halt, instr_cnt
    );

    modport slave (
        output instr, stat,
        input  ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we,
               wb_sel, rb_sel, alu_op, dm_we, halt, instr_cnt
    );
endinterface

// File: rtl/ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ctrl_fsm
// Multi-cycle control unit for the SISC processor. Sequences each instruction
// through FETCH / DECODE / EXECUTE / MEM / WB, evaluates branch conditions
// against the status register, drives all datapath enables and selects, and
// counts retired instructions.
//
// Cycles per instruction: NOP 2, branch 3, ALU/ADDI/STR 4, LOD 5.
// Control outputs are combinational from the current state and the opcode
// held in the IR, so an asynchronous reset clears them in the same cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       ctrl_fsm_if.master (instr/stat in, all controls out)
//
// Build option:
//   CTRL_ILLEGAL_HALT_EN  when defined, undefined opcodes 8..E halt the
//                         processor like HLT; otherwise they retire as NOPs.
// ----------------------------------------------------------------------------
module ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_fsm_if.master   bus
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LOD  = 4'h3;
    localparam logic [3:0] OP_STR  = 4'h4;
    localparam logic [3:0] OP_BRA  = 4'h5;
    localparam logic [3:0] OP_BRR  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       opcode_s;
    logic [3:0]       mask_s;
    logic             taken_s;
    logic             retire_s;

    logic             ir_load_s;
    logic             pc_write_s;
    logic             pc_sel_s;
    logic             br_sel_s;
    logic             pc_rst_s;
    logic             rf_we_s;
    logic             wb_sel_s;
    logic             rb_sel_s;
    logic [1:0]       alu_op_s;
    logic             dm_we_s;
    logic             halt_s;

    // Operand fields below the condition mask belong to the datapath.
    logic             unused_instr_s;

    assign opcode_s       = bus.instr[31:28];
    assign mask_s         = bus.instr[27:24];
    assign unused_instr_s = ^bus.instr[23:0];

    // Branch condition against the live status register (only consumed in EXECUTE).
    always_comb begin
        taken_s = 1'b0;
        case (opcode_s)
            OP_BRA, OP_BRR: taken_s = (mask_s == 4'd0) || ((mask_s & bus.stat) != 4'd0);
            OP_BNE:         taken_s = ((mask_s & bus.stat) == 4'd0);
            default:        taken_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, retire strobe and control outputs from state and opcode.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        ir_load_s    = 1'b0;
        pc_write_s   = 1'b0;
        pc_sel_s     = 1'b0;
        br_sel_s     = 1'b0;
        pc_rst_s     = 1'b0;
        rf_we_s      = 1'b0;
        wb_sel_s     = 1'b0;
        rb_sel_s     = 1'b0;
        alu_op_s     = 2'b10;
        dm_we_s      = 1'b0;
        halt_s       = 1'b0;

        case (state_r)
            S_RESET: begin
                pc_rst_s     = 1'b1;
                next_state_s = S_FETCH;
            end

            S_FETCH: begin
                ir_load_s    = 1'b1;
                pc_write_s   = 1'b1;
                pc_sel_s     = 1'b0;
                next_state_s = S_DECODE;
            end

            S_DECODE: begin
                case (opcode_s)
                    OP_NOP: begin
                        retire_s     = 1'b1;
                        next_state_s = S_FETCH;
                    end
                    OP_HLT: begin
                        retire_s     = 1'b1;
                        next_state_s = S_HALT;
                    end
                    OP_ALU, OP_ADDI, OP_LOD, OP_STR, OP_BRA, OP_BRR, OP_BNE: begin
                        next_state_s = S_EXECUTE;
                    end
                    default: begin
                        // Undefined opcode still counts as a retired instruction.
                        retire_s     = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
                        next_state_s = S_HALT;
`else
                        next_state_s = S_FETCH;
`endif
                    end
                endcase
            end

            S_EXECUTE: begin
                case (opcode_s)
                    OP_ALU: begin
                        alu_op_s     = 2'b00;
                        next_state_s = S_WB;
                    end
                    OP_ADDI: begin
                        alu_op_s     = 2'b11;
                        next_state_s = S_WB;
                    end
                    OP_LOD: begin
                        alu_op_s     = 2'b11;
                        next_state_s = S_MEM;
                    end
                    OP_STR: begin
                        alu_op_s     = 2'b11;
                        rb_sel_s     = 1'b1;
                        next_state_s = S_MEM;
                    end
                    default: begin
                        // Branches resolve here; a not-taken branch writes nothing.
                        retire_s     = 1'b1;
                        next_state_s = S_FETCH;
                        if (taken_s) begin
                            pc_write_s = 1'b1;
                            pc_sel_s   = 1'b1;
                            br_sel_s   = (opcode_s == OP_BRA);
                        end else begin
                            pc_write_s = 1'b0;
                        end
                    end
                endcase
            end

            S_MEM: begin
                alu_op_s = 2'b11;
                if (opcode_s == OP_STR) begin
                    rb_sel_s     = 1'b1;
                    dm_we_s      = 1'b1;
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_WB;
                end
            end

            S_WB: begin
                rf_we_s      = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
                case (opcode_s)
                    OP_ALU:  alu_op_s = 2'b00;
                    OP_ADDI: alu_op_s = 2'b11;
                    OP_LOD: begin
                        alu_op_s = 2'b11;
                        wb_sel_s = 1'b1;
                    end
                    default: alu_op_s = 2'b10;
                endcase
            end

            S_HALT: begin
                halt_s       = 1'b1;
                next_state_s = S_HALT;
            end

            default: begin
                next_state_s = S_RESET;
            end
        endcase
    end

    // Retired-instruction counter; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (retire_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.ir_load   = ir_load_s;
    assign bus.pc_write  = pc_write_s;
    assign bus.pc_sel    = pc_sel_s;
    assign bus.br_sel    = br_sel_s;
    assign bus.pc_rst    = pc_rst_s;
    assign bus.rf_we     = rf_we_s;
    assign bus.wb_sel    = wb_sel_s;
    assign bus.rb_sel    = rb_sel_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.dm_we     = dm_we_s;
    assign bus.halt      = halt_s;
    assign bus.instr_cnt = cnt_r;

endmodule

// File: tb/tb_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_ctrl_fsm
// Scoreboard bench for ctrl_fsm. Each instruction queues its expected
// per-cycle control vector and counter value; the records are popped one per
// clock and compared shortly after the falling edge. A narrow counter makes
// the wrap-around reachable in a short run.
// Output vector bit order:
//   {ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, rb_sel,
//    alu_op[1:0], dm_we, halt}
// ----------------------------------------------------------------------------
module tb_ctrl_fsm;

    localparam int CW = 4;

    localparam logic [11:0] V_FETCH   = 12'b1100_0000_1000;
    localparam logic [11:0] V_IDLE    = 12'b0000_0000_1000;
    localparam logic [11:0] V_RST     = 12'b0000_1000_1000;
    localparam logic [11:0] V_HALT    = 12'b0000_0000_1001;
    localparam logic [11:0] V_EX_ALU  = 12'b0000_0000_0000;
    localparam logic [11:0] V_EX_IMM  = 12'b0000_0000_1100;
    localparam logic [11:0] V_EX_STR  = 12'b0000_0001_1100;
    localparam logic [11:0] V_MEM_STR = 12'b0000_0001_1110;
    localparam logic [11:0] V_WB_ALU  = 12'b0000_0100_0000;
    localparam logic [11:0] V_WB_IMM  = 12'b0000_0100_1100;
    localparam logic [11:0] V_WB_LOD  = 12'b0000_0110_1100;
    localparam logic [11:0] V_BR_ABS  = 12'b0111_0000_1000;
    localparam logic [11:0] V_BR_REL  = 12'b0110_0000_1000;

    typedef struct {
        logic [31:0]   ins;
        logic [3:0]    st;
        logic [11:0]   vec;
        logic [CW-1:0] cnt;
    } rec_t;

    logic          clk;
    logic          rst_n;
    rec_t          sb_q[$];
    int            n_vec;
    int            n_err;
    logic [CW-1:0] cnt_m;
    logic [11:0]   obs;

    ctrl_fsm_if #(.CNT_W(CW)) dif ();

    ctrl_fsm #(.CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    assign obs = {dif.ir_load, dif.pc_write, dif.pc_sel, dif.br_sel, dif.pc_rst,
                  dif.rf_we, dif.wb_sel, dif.rb_sel, dif.alu_op, dif.dm_we, dif.halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] ins, input logic [3:0] st, input logic [11:0] vec);
        rec_t r;
        r.ins = ins;
        r.st  = st;
        r.vec = vec;
        r.cnt = cnt_m;
        sb_q.push_back(r);
    endtask

    // Expected per-cycle vectors for one instruction, starting at its FETCH.
    task automatic push_instr(input logic [31:0] ins, input logic [3:0] st);
        logic [3:0] op;
        logic [3:0] mk;
        logic       tk;
        op = ins[31:28];
        mk = ins[27:24];
        push(ins, st, V_FETCH);
        push(ins, st, V_IDLE);
        case (op)
            4'h1: begin push(ins, st, V_EX_ALU); push(ins, st, V_WB_ALU); end
            4'h2: begin push(ins, st, V_EX_IMM); push(ins, st, V_WB_IMM); end
            4'h3: begin push(ins, st, V_EX_IMM); push(ins, st, V_EX_IMM); push(ins, st, V_WB_LOD); end
            4'h4: begin push(ins, st, V_EX_STR); push(ins, st, V_MEM_STR); end
            4'h5, 4'h6: begin
                tk = (mk == 4'd0) || ((mk & st) != 4'd0);
                push(ins, st, tk ? ((op == 4'h5) ? V_BR_ABS : V_BR_REL) : V_IDLE);
            end
            4'h7: begin
                tk = ((mk & st) == 4'd0);
                push(ins, st, tk ? V_BR_REL : V_IDLE);
            end
            default: begin end
        endcase
        cnt_m = cnt_m + 1'b1;
    endtask

    task automatic push_halt(input logic [31:0] ins, input int n);
        for (int i = 0; i < n; i++) push(ins, 4'd0, V_HALT);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cnt_m = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (obs !== V_RST || dif.instr_cnt !== 4'd0) begin
                n_err++;
                $display("FAIL reset: outs=%b cnt=%0d, want outs=%b cnt=0", obs, dif.instr_cnt, V_RST);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        rec_t e;
        push_instr(32'h1000_0001, 4'd0);
        push_instr(32'h2000_0005, 4'd0);
        push_instr(32'h1000_0003, 4'd0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL alu: ins=%h outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_mem();
        rec_t e;
        push_instr(32'h3012_0004, 4'd0);
        push_instr(32'h4034_0008, 4'd0);
        push_instr(32'h3056_0001, 4'd0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL mem: ins=%h outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        rec_t e;
        push_instr(32'h6100_0010, 4'b0001);
        push_instr(32'h6100_0010, 4'b0000);
        push_instr(32'h7100_0010, 4'b0001);
        push_instr(32'h7100_0010, 4'b0000);
        push_instr(32'h5000_0040, 4'b0000);
        push_instr(32'h5500_0040, 4'b1010);
        push_instr(32'h6C00_0020, 4'b0100);
        push_instr(32'h7000_0020, 4'b1111);
        push_instr(32'h5800_0030, 4'b1000);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL branch: ins=%h stat=%b outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, e.st, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_illegal();
        rec_t e;
        push_instr(32'hA000_0000, 4'd0);
`ifdef CTRL_ILLEGAL_HALT_EN
        push_halt(32'hA000_0000, 20);
`else
        push_instr(32'hE000_0000, 4'd0);
        push_instr(32'h1000_0001, 4'd0);
`endif
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL illegal: ins=%h outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
`ifdef CTRL_ILLEGAL_HALT_EN
        rst_n = 1'b0;
        cnt_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_abort();
        rec_t e;
        push_instr(32'h3000_0002, 4'd0);
        // Walk FETCH, DECODE, EXECUTE, MEM, then reset inside MEM.
        for (int i = 0; i < 4; i++) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL abort_pre: ins=%h outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
        sb_q.delete();
        #1;
        rst_n = 1'b0;
        cnt_m = '0;
        #1;
        n_vec++;
        if (obs !== V_RST || dif.instr_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL abort_now: outs=%b cnt=%0d, want outs=%b cnt=0", obs, dif.instr_cnt, V_RST);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (obs !== V_RST || dif.rf_we !== 1'b0) begin
                n_err++;
                $display("FAIL abort_hold: outs=%b rf_we=%b, want outs=%b rf_we=0", obs, dif.rf_we, V_RST);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        rec_t e;
        // Counter starts at 0 after the abort; 17 NOPs pass 15 -> 0.
        for (int i = 0; i < 17; i++) push_instr(32'h0000_0000, 4'd0);
        push_instr(32'h1000_0001, 4'd0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL wrap: ins=%h outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_halt();
        rec_t e;
        push_instr(32'hF000_0000, 4'd0);
        push_halt(32'hF000_0000, 20);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            dif.instr = e.ins; dif.stat = e.st;
            #1;
            n_vec++;
            if (obs !== e.vec || dif.instr_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL halt: ins=%h outs=%b cnt=%0d, want outs=%b cnt=%0d", e.ins, obs, dif.instr_cnt, e.vec, e.cnt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at 100000, want finished");
        $fatal(1);
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cnt_m     = '0;
        dif.instr = 32'h0000_0000;
        dif.stat  = 4'd0;
        rst_n     = 1'b1;
        #2;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
        test_abort();
        test_wrap();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
